// File: rtl/nand4_resp_checker_v.sv
// -----------------------------------------------------------------------------
// nand4_resp_checker_v
//
// Response checker for 4-input NAND gate variants. Each strobed stimulus
// vector is captured and its expected NAND4 value computed. The gate output is
// sampled SETTLE_CYC clocks later and compared against that expected value.
// Passes and fails are counted, the first failure is recorded, and o_done is
// raised after NUM_VEC compares.
//
// Optional feature (compile-time macro NAND4_CHK_STOP_ON_FAIL_EN):
//   defined   -> the first mismatch ends the run immediately (DONE)
//   undefined -> every run checks all NUM_VEC vectors
//
// Parameters:
//   NUM_VEC    vectors per run (1..255)
//   SETTLE_CYC clocks from vector capture to output sample (>= 1)
//   ERR_W      width of the pass/fail counters
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          synchronous reset, active low
//   i_start          one-cycle pulse: clear results and arm a run
//   i_vec_valid      one-cycle strobe: i_vec holds an applied vector
//   i_vec[3:0]       applied stimulus (bit 3 = a ... bit 0 = d)
//   i_f              gate output under check
//   o_busy           run in progress (ARMED, SETTLE, CMP)
//   o_done           run complete, results holding
//   o_pass_cnt       matching compares, saturating
//   o_fail_cnt       mismatching compares, saturating
//   o_first_fail_idx vector index of the first mismatch
//   o_first_fail_vec vector of the first mismatch
//   o_overrun        sticky: a vector arrived while a compare was pending
// -----------------------------------------------------------------------------
module nand4_resp_checker_v #(
    parameter int NUM_VEC    = 18,
    parameter int SETTLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_vec_valid,
    input  logic [3:0]       i_vec,
    input  logic             i_f,
    output logic             o_busy,
    output logic             o_done,
    output logic [ERR_W-1:0] o_pass_cnt,
    output logic [ERR_W-1:0] o_fail_cnt,
    output logic [7:0]       o_first_fail_idx,
    output logic [3:0]       o_first_fail_vec,
    output logic             o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SETTLE,
        S_CMP,
        S_DONE
    } state_t;

    localparam int                CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [7:0]        LAST_IDX    = 8'(NUM_VEC - 1);

`ifdef NAND4_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t           state;
    state_t           state_next;
    logic [7:0]       idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [3:0]       vec_q;
    logic             exp_q;
    logic             f_q;
    logic             cmp_match;
    logic             run_end;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        // Case equality: an X/Z sampled from the gate never counts as a match.
        cmp_match  = (f_q === exp_q);
        run_end    = (idx == LAST_IDX) || (STOP_ON_FAIL && !cmp_match);

        unique case (state)
            S_IDLE:   if (i_start) state_next = S_ARMED;
            S_ARMED: begin
                if (i_start)          state_next = S_ARMED;
                else if (i_vec_valid) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (i_start)                 state_next = S_ARMED;
                else if (settle_cnt == '0)   state_next = S_CMP;
            end
            S_CMP: begin
                if (i_start)      state_next = S_ARMED;
                else if (run_end) state_next = S_DONE;
                else              state_next = S_ARMED;
            end
            S_DONE:   if (i_start) state_next = S_ARMED;
            default:  state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            idx              <= '0;
            settle_cnt       <= '0;
            vec_q            <= '0;
            exp_q            <= 1'b0;
            f_q              <= 1'b0;
            o_pass_cnt       <= '0;
            o_fail_cnt       <= '0;
            o_first_fail_idx <= '0;
            o_first_fail_vec <= '0;
            o_overrun        <= 1'b0;
        end else begin
            state <= state_next;

            if (i_start) begin
                // A start in any state begins a fresh run; an in-flight
                // vector is simply abandoned.
                idx              <= '0;
                settle_cnt       <= '0;
                o_pass_cnt       <= '0;
                o_fail_cnt       <= '0;
                o_first_fail_idx <= '0;
                o_first_fail_vec <= '0;
                o_overrun        <= 1'b0;
            end else begin
                unique case (state)
                    S_ARMED: begin
                        if (i_vec_valid) begin
                            vec_q      <= i_vec;
                            exp_q      <= ~&i_vec;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                    S_SETTLE: begin
                        if (i_vec_valid) o_overrun <= 1'b1;
                        // The gate output is registered on the edge that leaves
                        // SETTLE, which is exactly SETTLE_CYC clocks after capture.
                        if (settle_cnt == '0) f_q        <= i_f;
                        else                  settle_cnt <= settle_cnt - 1'b1;
                    end
                    S_CMP: begin
                        if (i_vec_valid) o_overrun <= 1'b1;
                        if (cmp_match) begin
                            if (o_pass_cnt != '1) o_pass_cnt <= o_pass_cnt + 1'b1;
                        end else begin
                            if (o_fail_cnt != '1) o_fail_cnt <= o_fail_cnt + 1'b1;
                            if (o_fail_cnt == '0) begin
                                o_first_fail_idx <= idx;
                                o_first_fail_vec <= vec_q;
                            end
                        end
                        if (!run_end) idx <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_busy = (state == S_ARMED) || (state == S_SETTLE) || (state == S_CMP);
    assign o_done = (state == S_DONE);

endmodule

// File: tb/tb_nand4_resp_checker_v.sv
// -----------------------------------------------------------------------------
// tb_nand4_resp_checker_v
//
// Directed and randomized bench for nand4_resp_checker_v. A gate model drives
// i_f (correct, stuck-at-1, stuck-at-0, or a single faulty input pattern);
// a reference model counts expected passes/fails from the NAND4 truth rule.
// Honours NAND4_CHK_STOP_ON_FAIL_EN when the same macro is defined.
// -----------------------------------------------------------------------------
module tb_nand4_resp_checker_v;

    localparam int NUM = 18;

    localparam int M_GOOD = 0;
    localparam int M_SA1  = 1;
    localparam int M_SA0  = 2;
    localparam int M_ONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       vec_valid;
    logic [3:0] vec;
    logic       f;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
    logic [7:0] first_fail_idx;
    logic [3:0] first_fail_vec;
    logic       overrun;

    int         mode;
    logic [3:0] fault_vec;
    logic [3:0] vecs [NUM];

    int tests  = 0;
    int failed = 0;

    nand4_resp_checker_v #(
        .NUM_VEC   (NUM),
        .SETTLE_CYC(4),
        .ERR_W     (8)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_vec_valid     (vec_valid),
        .i_vec           (vec),
        .i_f             (f),
        .o_busy          (busy),
        .o_done          (done),
        .o_pass_cnt      (pass_cnt),
        .o_fail_cnt      (fail_cnt),
        .o_first_fail_idx(first_fail_idx),
        .o_first_fail_vec(first_fail_vec),
        .o_overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Behaviour of the gate under test.
    function automatic logic gate_out(int m, logic [3:0] v, logic [3:0] fv);
        case (m)
            M_SA1:   return 1'b1;
            M_SA0:   return 1'b0;
            M_ONE:   return (v == fv) ? (v == 4'hF) : (v != 4'hF);
            default: return (v != 4'hF);
        endcase
    endfunction

    assign f = gate_out(mode, vec, fault_vec);

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One vector every 10 clocks; optionally a duplicate strobe 2 clocks
    // after capture, which must be dropped and flagged as overrun.
    task automatic apply_vec(logic [3:0] v, bit dup);
        @(negedge clk);
        vec       = v;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        if (dup) vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full run: program the gate model, drive all vectors, then compare the
    // results against a reference computed from the NAND4 rule.
    task automatic run_set(string tag, int m, logic [3:0] fv, int dup_at, bit exp_ovr);
        int         e_pass;
        int         e_fail;
        int         e_idx;
        logic [3:0] e_vec;
        bit         stopped;
        bit         good;
        int         k;

        mode      = m;
        fault_vec = fv;
        pulse_start();
        check({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < NUM; i++) apply_vec(vecs[i], i == dup_at);

        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".done"}, 32'(done), 32'd1);

        e_pass  = 0;
        e_fail  = 0;
        e_idx   = 0;
        e_vec   = 4'h0;
        stopped = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (!stopped) begin
                good = (gate_out(m, vecs[i], fv) == (vecs[i] != 4'hF));
                if (good) e_pass++;
                else begin
                    if (e_fail == 0) begin
                        e_idx = i;
                        e_vec = vecs[i];
                    end
                    e_fail++;
`ifdef NAND4_CHK_STOP_ON_FAIL_EN
                    stopped = 1'b1;
`endif
                end
            end
        end

        check({tag, ".pass"},     32'(pass_cnt),       32'(e_pass));
        check({tag, ".fail"},     32'(fail_cnt),       32'(e_fail));
        check({tag, ".ff_idx"},   32'(first_fail_idx), 32'(e_idx));
        check({tag, ".ff_vec"},   32'(first_fail_vec), 32'(e_vec));
        check({tag, ".overrun"},  32'(overrun),        32'(exp_ovr));
        check({tag, ".busy_end"}, 32'(busy),           32'd0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, ".busy"},    32'(busy),           32'd0);
        check({tag, ".done"},    32'(done),           32'd0);
        check({tag, ".pass"},    32'(pass_cnt),       32'd0);
        check({tag, ".fail"},    32'(fail_cnt),       32'd0);
        check({tag, ".ff_idx"},  32'(first_fail_idx), 32'd0);
        check({tag, ".ff_vec"},  32'(first_fail_vec), 32'd0);
        check({tag, ".overrun"}, 32'(overrun),        32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_valid = 1'b0;
        vec       = 4'h0;
        mode      = M_GOOD;
        fault_vec = 4'h0;
        for (int i = 0; i < NUM; i++) vecs[i] = 4'(i % 16);

        // Reset state; a strobe while idle must not raise overrun.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        check("idle_strobe.overrun", 32'(overrun), 32'd0);
        check("idle_strobe.busy",    32'(busy),    32'd0);

        // Counting vectors 0..15, 0, 1 with the standard gate models.
        run_set("good", M_GOOD, 4'h0, -1, 1'b0);
        run_set("sa1",  M_SA1,  4'h0, -1, 1'b0);
        run_set("sa0",  M_SA0,  4'h0, -1, 1'b0);

        // Duplicate strobe during SETTLE of vector 3.
        run_set("ovr",  M_GOOD, 4'h0, 3, 1'b1);

        // Restart mid-run: a partial faulty run is cleared by a new start.
        mode = M_SA0;
        pulse_start();
        for (int i = 0; i < 3; i++) apply_vec(vecs[i], 1'b0);
        run_set("restart", M_GOOD, 4'h0, -1, 1'b0);

        // Reset for one clock during SETTLE of vector 7.
        mode = M_SA0;
        pulse_start();
        for (int i = 0; i < 7; i++) apply_vec(vecs[i], 1'b0);
        @(negedge clk);
        vec       = vecs[7];
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midreset");
        run_set("post_reset", M_GOOD, 4'h0, -1, 1'b0);

        // Randomized vectors with a single faulty input pattern.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM; i++) vecs[i] = 4'($urandom_range(0, 15));
            run_set($sformatf("rand%0d", r), M_ONE, 4'($urandom_range(0, 15)), -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
